// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if
//   Bundles the requester-side handshake and the UART TX-side signals of the
//   round-robin UART TX arbiter.
//   Modports:
//     master : the arbiter (drives req_ready, tx_p_data, tx_data_valid,
//              grant_id, timeout_err; samples req_valid, req_data, tx_busy)
//     slave  : the surrounding requesters and UART TX controller
//   Signals:
//     req_valid     [NREQ]            per-requester byte pending
//     req_data      [NREQ*DATA_WIDTH] requester i byte at [i*DATA_WIDTH +: DATA_WIDTH]
//     req_ready     [NREQ]            one-hot accept pulse
//     tx_busy                         busy flag from the UART TX controller
//     tx_p_data     [DATA_WIDTH]      byte handed to the UART TX
//     tx_data_valid                   one-cycle start pulse to the UART TX
//     grant_id      [clog2(NREQ)]     last/current granted requester
//     timeout_err                     sticky busy-never-rose flag
interface uart_tx_arbiter_if #(
  parameter int NREQ       = 4,
  parameter int DATA_WIDTH = 8
);
  localparam int ID_W = $clog2(NREQ);

  logic [NREQ-1:0]            req_valid;
  logic [NREQ*DATA_WIDTH-1:0] req_data;
  logic [NREQ-1:0]            req_ready;
  logic                       tx_busy;
  logic [DATA_WIDTH-1:0]      tx_p_data;
  logic                       tx_data_valid;
  logic [ID_W-1:0]            grant_id;
  logic                       timeout_err;

  modport master (
    input  req_valid, req_data, tx_busy,
    output req_ready, tx_p_data, tx_data_valid, grant_id, timeout_err
  );

  modport slave (
    output req_valid, req_data, tx_busy,
    input  req_ready, tx_p_data, tx_data_valid, grant_id, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin scheduler sharing one UART TX datapath between NREQ byte
//   producers. A pending requester is picked (scan from rr_ptr with
//   wrap-around), its byte is captured, a one-cycle tx_data_valid is issued,
//   and the arbiter then follows tx_busy through the whole frame before it
//   grants again. If tx_busy never rises within TIMEOUT cycles the byte is
//   dropped and the sticky timeout_err is set.
//   Ports:
//     clk    UART TX clock
//     rst_n  asynchronous active-low reset
//     bus    uart_tx_arbiter_if.master (requester handshake + UART TX side)
//   Parameters: NREQ (2..8), DATA_WIDTH, TIMEOUT (>= 2)
//   Optional feature: define UART_TX_ARB_PRIO0_EN to give requester 0
//   absolute priority; requesters 1..NREQ-1 stay round-robin among themselves.
module uart_tx_arbiter #(
  parameter int NREQ       = 4,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 15
) (
  input logic              clk,
  input logic              rst_n,
  uart_tx_arbiter_if.master bus
);
  localparam int ID_W  = $clog2(NREQ);
  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_START, WAIT_DONE} state_t;

  state_t                state;
  logic [ID_W-1:0]       rr_ptr;
  logic [CNT_W-1:0]      cnt;

  logic [NREQ-1:0]       rr_cand;
  logic                  prio0_hit;
  logic                  rr_found;
  logic [ID_W-1:0]       rr_winner;
  logic [ID_W-1:0]       winner;
  logic                  any_req;
  logic [DATA_WIDTH-1:0] win_data;
  logic [ID_W:0]         scan_sum;
  logic [ID_W-1:0]       scan_idx;

  function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] w);
    if (w == ID_W'(NREQ - 1)) return '0;
    else                      return w + 1'b1;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [ID_W-1:0] w);
    return {{(NREQ-1){1'b0}}, 1'b1} << w;
  endfunction

`ifdef UART_TX_ARB_PRIO0_EN
  // Requester 0 bypasses the rotation, so it is removed from the scan.
  assign prio0_hit = bus.req_valid[0];
  assign rr_cand   = {bus.req_valid[NREQ-1:1], 1'b0};
`else
  assign prio0_hit = 1'b0;
  assign rr_cand   = bus.req_valid;
`endif

  // Scan from rr_ptr upward with wrap-around; first pending candidate wins.
  always_comb begin
    rr_found  = 1'b0;
    rr_winner = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int i = 0; i < NREQ; i++) begin
      scan_sum = {1'b0, rr_ptr} + (ID_W+1)'(i);
      if (scan_sum >= (ID_W+1)'(NREQ)) scan_sum = scan_sum - (ID_W+1)'(NREQ);
      scan_idx = scan_sum[ID_W-1:0];
      if (!rr_found && rr_cand[scan_idx]) begin
        rr_found  = 1'b1;
        rr_winner = scan_idx;
      end
    end
  end

  assign winner  = prio0_hit ? '0 : rr_winner;
  assign any_req = prio0_hit | rr_found;

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == ID_W'(i)) win_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      rr_ptr            <= '0;
      cnt               <= '0;
      bus.req_ready     <= '0;
      bus.tx_p_data     <= '0;
      bus.tx_data_valid <= 1'b0;
      bus.grant_id      <= '0;
      bus.timeout_err   <= 1'b0;
    end else begin
      // Both strobes are single-cycle pulses unless re-asserted below.
      bus.req_ready     <= '0;
      bus.tx_data_valid <= 1'b0;
      case (state)
        IDLE: begin
          // A busy UART (even a spurious one) simply holds off arbitration.
          if (any_req && !bus.tx_busy) begin
            bus.tx_p_data <= win_data;
            bus.grant_id  <= winner;
            bus.req_ready <= onehot(winner);
            // A priority grant to requester 0 leaves the rotation untouched.
            if (!prio0_hit) rr_ptr <= next_ptr(winner);
            state <= LOAD;
          end
        end
        LOAD: begin
          bus.tx_data_valid <= 1'b1;
          cnt               <= '0;
          state             <= WAIT_START;
        end
        WAIT_START: begin
          if (bus.tx_busy) begin
            state <= WAIT_DONE;
          end else if (cnt == CNT_W'(TIMEOUT - 2)) begin
            // Counter would reach TIMEOUT-1 on this edge: give up on the byte.
            bus.timeout_err <= 1'b1;
            cnt             <= '0;
            state           <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!bus.tx_busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//   Scoreboard bench for uart_tx_arbiter. Stimulus pushes the expected
//   req_ready one-hot and {grant_id, byte} of every frame it provokes; a
//   monitor pops and compares whenever the DUT pulses req_ready or
//   tx_data_valid. A small UART model raises tx_busy one cycle after
//   tx_data_valid and holds it for 11 cycles.
module tb_uart_tx_arbiter;
  localparam int NREQ    = 4;
  localparam int DW      = 8;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NREQ(NREQ), .DATA_WIDTH(DW)) bus ();

  uart_tx_arbiter #(.NREQ(NREQ), .DATA_WIDTH(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic model_busy = 1'b0;
  logic force_busy = 1'b0;
  logic uart_en    = 1'b1;
  assign bus.tx_busy = model_busy | force_busy;

  int n_checks = 0;
  int n_errors = 0;
  logic [NREQ-1:0] exp_ready_q[$];
  logic [9:0]      exp_tx_q[$];
  int remaining[NREQ];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_frame(input int id, input logic [7:0] data);
    logic [NREQ-1:0] oh;
    logic [1:0]      id2;
    oh  = 4'b0001 << id;
    id2 = 2'(id);
    exp_ready_q.push_back(oh);
    exp_tx_q.push_back({id2, data});
  endtask

  // Monitor / scoreboard plus requester behaviour (drop valid after last byte).
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (bus.req_ready != '0) begin
          if (exp_ready_q.size() == 0) check("unexpected_req_ready", 32'(bus.req_ready), 0);
          else check("req_ready", 32'(bus.req_ready), 32'(exp_ready_q.pop_front()));
        end
        if (bus.tx_data_valid) begin
          if (exp_tx_q.size() == 0) check("unexpected_tx_data_valid", {bus.grant_id, bus.tx_p_data}, 32'h3ff);
          else check("tx_grant_and_byte", 32'({bus.grant_id, bus.tx_p_data}), 32'(exp_tx_q.pop_front()));
        end
        for (int i = 0; i < NREQ; i++) begin
          if (bus.req_ready[i] && remaining[i] > 0) begin
            remaining[i]--;
            if (remaining[i] == 0) bus.req_valid[i] = 1'b0;
          end
        end
      end
    end
  end

  // UART TX model.
  initial begin
    forever begin
      @(negedge clk);
      if (uart_en && rst_n === 1'b1 && bus.tx_data_valid) begin
        @(negedge clk);
        if (rst_n === 1'b1) begin
          model_busy = 1'b1;
          for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            if (rst_n !== 1'b1) break;
          end
          model_busy = 1'b0;
        end
      end
    end
  end

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    force_busy    = 1'b0;
    uart_en       = 1'b1;
    for (int i = 0; i < NREQ; i++) remaining[i] = 0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({bus.req_ready, bus.tx_data_valid, bus.tx_p_data,
                                bus.grant_id, bus.timeout_err}), 0);
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    int streak;
    int budget;
    streak = 0;
    budget = 0;
    while (streak < 4 && budget < 1000) begin
      @(negedge clk);
      budget++;
      if (exp_ready_q.size() == 0 && exp_tx_q.size() == 0 && !bus.tx_busy && !bus.tx_data_valid)
        streak++;
      else
        streak = 0;
    end
    check({name, "_drained_in_time"}, 32'(streak >= 4), 1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not end, errors so far %0d", n_errors);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic seen;
    logic early;
    int   guard;

    // Single request, latency, and no regrant while busy.
    do_reset();
    bus.req_data = {8'h00, 8'hA5, 8'h00, 8'h00};
    remaining[2] = 2;
    expect_frame(2, 8'hA5);
    expect_frame(2, 8'hA5);
    bus.req_valid = 4'b0100;
    @(negedge clk);
    check("t1_ready_at_edge1", 32'(bus.req_ready), 32'h4);
    check("t1_dv_low_at_edge1", 32'(bus.tx_data_valid), 0);
    @(negedge clk);
    check("t1_dv_at_edge2", 32'(bus.tx_data_valid), 1);
    check("t1_byte", 32'(bus.tx_p_data), 32'hA5);
    check("t1_grant_id", 32'(bus.grant_id), 2);
    @(negedge clk);
    check("t1_dv_one_cycle", 32'(bus.tx_data_valid), 0);
    guard = 0;
    while (!bus.tx_busy && guard < 5) begin @(negedge clk); guard++; end
    check("t1_busy_rose", 32'(bus.tx_busy), 1);
    seen = 1'b0;
    guard = 0;
    while (bus.tx_busy && guard < 30) begin
      if (bus.req_ready != '0 || bus.tx_data_valid) seen = 1'b1;
      @(negedge clk);
      guard++;
    end
    check("t1_no_grant_while_busy", 32'(seen), 0);
    wait_idle("t1");

    // Fairness: all four pending, two bytes each.
    do_reset();
    bus.req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int i = 0; i < NREQ; i++) remaining[i] = 2;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NREQ; i++) expect_frame(i, 8'h10 + 8'(i));
    bus.req_valid = 4'b1111;
    wait_idle("t2");
    check("t2_no_timeout", 32'(bus.timeout_err), 0);

    // Busy held high blocks arbitration; grant on the edge after release.
    do_reset();
    force_busy   = 1'b1;
    bus.req_data = {8'h00, 8'h00, 8'h5A, 8'h00};
    remaining[1] = 1;
    bus.req_valid = 4'b0010;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.req_ready != '0 || bus.tx_data_valid) seen = 1'b1;
    end
    check("t3_blocked_while_busy", 32'(seen), 0);
    expect_frame(1, 8'h5A);
    force_busy = 1'b0;
    @(negedge clk);
    check("t3_grant_after_release", 32'(bus.req_ready), 32'h2);
    wait_idle("t3");
    check("t3_spurious_busy_no_err", 32'(bus.timeout_err), 0);

    // Timeout: busy never rises.
    do_reset();
    uart_en      = 1'b0;
    bus.req_data = {8'h3C, 8'h00, 8'h00, 8'h00};
    remaining[3] = 1;
    expect_frame(3, 8'h3C);
    bus.req_valid = 4'b1000;
    @(negedge clk);
    check("t4_ready", 32'(bus.req_ready), 32'h8);
    early = 1'b0;
    for (int k = 1; k <= TIMEOUT; k++) begin
      @(negedge clk);
      if (k < TIMEOUT) early = early | bus.timeout_err;
    end
    check("t4_err_not_early", 32'(early), 0);
    check("t4_err_at_timeout", 32'(bus.timeout_err), 1);
    uart_en      = 1'b1;
    bus.req_data = {8'h3C, 8'h00, 8'h77, 8'h00};
    remaining[1] = 1;
    expect_frame(1, 8'h77);
    bus.req_valid = 4'b0010;
    @(negedge clk);
    check("t4_regrant_after_timeout", 32'(bus.req_ready), 32'h2);
    wait_idle("t4");
    check("t4_err_sticky", 32'(bus.timeout_err), 1);

    // Reset in the middle of a frame.
    do_reset();
    bus.req_data = {8'h00, 8'h99, 8'h00, 8'h00};
    remaining[2] = 1;
    expect_frame(2, 8'h99);
    bus.req_valid = 4'b0100;
    guard = 0;
    while (!bus.tx_busy && guard < 20) begin @(negedge clk); guard++; end
    check("t5_reached_busy", 32'(bus.tx_busy), 1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("t5_async_reset_outputs", 32'({bus.req_ready, bus.tx_data_valid, bus.tx_p_data,
                                             bus.grant_id, bus.timeout_err}), 0);
    for (int i = 0; i < NREQ; i++) remaining[i] = 0;
    remaining[0]  = 1;
    bus.req_data  = {8'h00, 8'h00, 8'h00, 8'h42};
    bus.req_valid = 4'b0001;
    repeat (3) @(negedge clk);
    expect_frame(0, 8'h42);
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_ready_after_reset", 32'(bus.req_ready), 32'h1);
    check("t5_grant_id_after_reset", 32'(bus.grant_id), 0);
    wait_idle("t5");

    // Requester 0 keeps presenting bytes while the others each have one.
    do_reset();
    bus.req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    remaining[0] = 3;
    remaining[1] = 1;
    remaining[2] = 1;
    remaining[3] = 1;
`ifdef UART_TX_ARB_PRIO0_EN
    expect_frame(0, 8'h10);
    expect_frame(0, 8'h10);
    expect_frame(0, 8'h10);
    expect_frame(1, 8'h11);
    expect_frame(2, 8'h12);
    expect_frame(3, 8'h13);
`else
    expect_frame(0, 8'h10);
    expect_frame(1, 8'h11);
    expect_frame(2, 8'h12);
    expect_frame(3, 8'h13);
    expect_frame(0, 8'h10);
    expect_frame(0, 8'h10);
`endif
    bus.req_valid = 4'b1111;
    wait_idle("t6");
    check("t6_all_requesters_done", 32'(bus.req_valid), 0);

    check("scoreboard_empty", exp_ready_q.size() + exp_tx_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin scheduler that shares the single UART TX datapath (serializer, parity and FSM controller) between NREQ byte-producing requesters. It picks one pending requester, captures its byte, and issues a one-cycle data_valid to the UART TX. It then tracks the TX busy flag through the whole frame before it grants again. It sits between the system controller or register-file readback sources and the UART TX top, in the UART TX clock domain.

Parameters:
NREQ, 4, number of requesters (2..8)
DATA_WIDTH, 8, byte width passed to UART TX
TIMEOUT, 15, max cycles to wait for tx_busy to rise after data_valid; minimum 2

Ports:
clk  input  1  UART TX clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  NREQ  per-requester byte pending; held high with stable data until req_ready pulse
req_data  input  NREQ*DATA_WIDTH  requester i byte at bits [i*DATA_WIDTH +: DATA_WIDTH]
req_ready  output  NREQ  one-hot, one-cycle pulse: byte of requester i accepted
tx_busy  input  1  busy from UART TX controller
tx_p_data  output  DATA_WIDTH  registered byte to UART TX
tx_data_valid  output  1  one-cycle start pulse to UART TX
grant_id  output  $clog2(NREQ)  index of last/current granted requester
timeout_err  output  1  sticky: tx_busy failed to rise within TIMEOUT cycles

Behaviour:
- Reset is asynchronous and active-low; clock is clk. In reset: tx_p_data=0, tx_data_valid=0, req_ready=0, grant_id=0, timeout_err=0, rr_ptr=0, state=IDLE, timeout counter=0.
- All outputs are registered.
- FSM states: IDLE, LOAD, WAIT_START, WAIT_DONE.
- IDLE: if any req_valid is high and tx_busy=0, pick winner w by scanning from rr_ptr upward with wrap-around. Next edge: tx_p_data<=req_data[w], grant_id<=w, req_ready[w]<=1, rr_ptr<=(w+1) mod NREQ, go to LOAD. If tx_busy=1, stay in IDLE and grant nothing.
- LOAD: req_ready returns to 0. tx_data_valid=1 for exactly this cycle. Go to WAIT_START and clear the counter.
- WAIT_START: tx_data_valid=0.
  - If tx_busy=1, go to WAIT_DONE.
  - Otherwise increment the counter. When it reaches TIMEOUT-1, set timeout_err=1 and go to IDLE; the byte is dropped and not retried.
- WAIT_DONE: stay until tx_busy=0, then go to IDLE. A new grant can be issued from IDLE on the following cycle, so the minimum gap is one idle cycle between frames.
- Latency: req_valid rising in IDLE with tx_busy=0 gives req_ready after 1 edge and tx_data_valid after 2 edges.
- A requester dropping req_valid before its grant is legal; that requester is skipped.
- A requester may keep req_valid high after req_ready to present its next byte. It is then considered only at the next IDLE, behind other pending requesters in round-robin order.
- Simultaneous requests: strict round-robin. Each requester is served at most once per NREQ grants while all others are pending.
- tx_busy rising spuriously in IDLE blocks arbitration and is not an error.
- timeout_err is cleared only by reset.
- Reset mid-frame: all state returns to reset values immediately. No req_ready is issued for an in-flight byte after reset.

Optional Feature:
Macro UART_TX_ARB_PRIO0_EN.
- Defined: requester 0 has absolute priority. If req_valid[0] is high in IDLE, it wins regardless of rr_ptr, and rr_ptr is left unchanged. Requesters 1..NREQ-1 stay round-robin among themselves.
- Undefined: pure round-robin over all NREQ requesters as described above.

Test Plan:
- Single request: reset, req_valid=4'b0100, req_data[2]=8'hA5, bench UART model raises busy 1 cycle after data_valid and holds it 11 cycles -> req_ready=4'b0100 at edge 1, tx_data_valid high 1 cycle at edge 2 with tx_p_data=8'hA5, grant_id=2, no further grant until busy falls.
- Fairness: all four req_valid held high with distinct bytes 8'h10..8'h13 for 8 frames -> grant order 0,1,2,3,0,1,2,3 and transmitted bytes in the same order.
- Blocking busy: tx_busy forced high while req_valid[1]=1 -> no req_ready and no tx_data_valid until busy drops; grant then occurs on the next edge.
- Timeout: busy never rises after data_valid -> timeout_err=1 exactly TIMEOUT cycles after LOAD, FSM back in IDLE, next request still granted, timeout_err stays 1.
- Reset mid-frame: assert rst_n=0 during WAIT_DONE -> all outputs 0 asynchronously. After release, pending req_valid=4'b0001 is granted with grant_id=0.
- UART_TX_ARB_PRIO0_EN defined: req_valid=4'b1111 held -> grant sequence 0,0,0 while req_valid[0] stays high. After req_valid[0] drops, grants 1,2,3 follow.
